// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue -- instruction queue between fetch (IF) and decode (ID).
//
// A circular buffer of DEPTH packed instruction entries. IF may push up to two
// entries per cycle; ID sees the two oldest entries and pops whatever is valid
// on a cycle where it asserts next_allowin_i. Either flush input empties the
// queue at the next edge and overrides any push/pop in that cycle.
//
// DEPTH must be a power of two and at least 4 so the pointers wrap naturally.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   line1/2_pre_to_now_valid_i  IF offers entry 1 / entry 2 (line2 needs line1)
//   line1/2_pre_to_ibus         entry payloads, line1 is the older
//   now_allowin_o               room for a full pair (registered state only)
//   next_allowin_i              ID consumes the presented entries this cycle
//   line1/2_now_to_next_valid_o head / head+1 entry valid
//   line1/2_to_next_obus        head / head+1 entry payloads
//   excep_flush_i               exception / ertn flush
//   branch_flush_i              branch mispredict flush
//   count_o                     current occupancy
// -----------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 160
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     line1_pre_to_now_valid_i,
    input  logic                     line2_pre_to_now_valid_i,
    input  logic [ENTRY_W-1:0]       line1_pre_to_ibus,
    input  logic [ENTRY_W-1:0]       line2_pre_to_ibus,
    output logic                     now_allowin_o,
    input  logic                     next_allowin_i,
    output logic                     line1_now_to_next_valid_o,
    output logic                     line2_now_to_next_valid_o,
    output logic [ENTRY_W-1:0]       line1_to_next_obus,
    output logic [ENTRY_W-1:0]       line2_to_next_obus,
    input  logic                     excep_flush_i,
    input  logic                     branch_flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int LANES = 2;

    // Payload storage is intentionally not reset; valids gate it.
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    logic          flush;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic [PW-1:0] wptr_p1;

    logic [LANES-1:0]              lane_vld;
    logic [LANES-1:0][ENTRY_W-1:0] lane_data;

    // Read lanes: lane k presents mem[rptr+k] and is valid when cnt > k.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PW-1:0] ridx;
        assign ridx         = rptr_q + PW'(k);
        assign lane_vld[k]  = cnt_q > CW'(k);
        assign lane_data[k] = mem_q[ridx];
    end

    assign line1_now_to_next_valid_o = lane_vld[0];
    assign line2_now_to_next_valid_o = lane_vld[1];
    assign line1_to_next_obus        = lane_data[0];
    assign line2_to_next_obus        = lane_data[1];

    // Always leave room for a full pair so IF never has to split one.
    assign now_allowin_o = cnt_q <= CW'(DEPTH - 2);
    assign count_o       = cnt_q;
    assign flush         = excep_flush_i | branch_flush_i;
    assign wptr_p1       = wptr_q + PW'(1);

    always_comb begin
        push_n = 2'd0;
        pop_n  = 2'd0;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;

        // A lone line2 valid is meaningless and dropped.
        if (now_allowin_o && line1_pre_to_now_valid_i)
            push_n = line2_pre_to_now_valid_i ? 2'd2 : 2'd1;

        if (next_allowin_i)
            pop_n = {1'b0, lane_vld[0]} + {1'b0, lane_vld[1]};

        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            rptr_d = rptr_q + PW'(pop_n);
            wptr_d = wptr_q + PW'(push_n);
            cnt_d  = cnt_q + CW'(push_n) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_n != 2'd0) mem_q[wptr_q]  <= line1_pre_to_ibus;
            if (push_n == 2'd2) mem_q[wptr_p1] <= line2_pre_to_ibus;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    localparam int DEPTH   = 8;
    localparam int ENTRY_W = 160;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               v1_i, v2_i, nai_i, ef_i, bf_i;
    logic [ENTRY_W-1:0] p1_i, p2_i;
    logic               allow_o, ov1_o, ov2_o;
    logic [ENTRY_W-1:0] o1_o, o2_o;
    logic [CW-1:0]      cnt_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] pc_ctr = 32'h1c00_0000;
    logic [ENTRY_W-1:0] sb [$];

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .line1_pre_to_now_valid_i  (v1_i),
        .line2_pre_to_now_valid_i  (v2_i),
        .line1_pre_to_ibus         (p1_i),
        .line2_pre_to_ibus         (p2_i),
        .now_allowin_o             (allow_o),
        .next_allowin_i            (nai_i),
        .line1_now_to_next_valid_o (ov1_o),
        .line2_now_to_next_valid_o (ov2_o),
        .line1_to_next_obus        (o1_o),
        .line2_to_next_obus        (o2_o),
        .excep_flush_i             (ef_i),
        .branch_flush_i            (bf_i),
        .count_o                   (cnt_o)
    );

    task automatic chk(input string tag, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", tag, act, exp);
        else n_pass++;
    endtask

    function automatic logic [ENTRY_W-1:0] mk(input logic [31:0] pc);
        return {$urandom(), $urandom(), $urandom(), $urandom(), pc};
    endfunction

    // Compare outputs against the scoreboard, then apply this cycle's
    // push/pop/flush to the model and advance one clock.
    task automatic cyc(input bit v1, input bit v2, input bit nai, input bit ef, input bit bf);
        int sz;
        bit allow;
        int npop;
        v1_i = v1; v2_i = v2; nai_i = nai; ef_i = ef; bf_i = bf;
        p1_i = mk(pc_ctr); p2_i = mk(pc_ctr + 32'd4);
        pc_ctr += 32'd8;
        #1;
        sz    = sb.size();
        allow = (sz <= DEPTH - 2);
        chk("count",   ENTRY_W'(cnt_o),   ENTRY_W'(sz));
        chk("allowin", ENTRY_W'(allow_o), ENTRY_W'(allow));
        chk("valid1",  ENTRY_W'(ov1_o),   ENTRY_W'(sz >= 1));
        chk("valid2",  ENTRY_W'(ov2_o),   ENTRY_W'(sz >= 2));
        if (sz >= 1) chk("data1", o1_o, sb[0]);
        if (sz >= 2) chk("data2", o2_o, sb[1]);
        if (ef || bf) begin
            sb.delete();
        end else begin
            npop = nai ? ((sz >= 2) ? 2 : sz) : 0;
            for (int i = 0; i < npop; i++) void'(sb.pop_front());
            if (allow && v1) begin
                sb.push_back(p1_i);
                if (v2) sb.push_back(p2_i);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_count",   ENTRY_W'(cnt_o),   '0);
        chk("rst_valid1",  ENTRY_W'(ov1_o),   '0);
        chk("rst_valid2",  ENTRY_W'(ov2_o),   '0);
        chk("rst_allowin", ENTRY_W'(allow_o), ENTRY_W'(1));
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        v1_i = 0; v2_i = 0; nai_i = 0; ef_i = 0; bf_i = 0;
        p1_i = '0; p2_i = '0;
        rst_n = 1'b1;
        #2;
        do_reset();

        // First pair with ID stalled; head must be the older pc.
        cyc(1, 1, 0, 0, 0);
        chk("first_pc1", ENTRY_W'(o1_o[31:0]), ENTRY_W'(32'h1c00_0000));
        chk("first_pc2", ENTRY_W'(o2_o[31:0]), ENTRY_W'(32'h1c00_0004));

        // Fill: pairs to 6, single to 7, then pushes must bounce.
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
        chk("full_cnt", ENTRY_W'(cnt_o), ENTRY_W'(7));

        // Drain to 1, then push pair while popping one.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Move both pointers to 6 while empty, then push across the wrap.
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // cnt=5 then branch flush with concurrent push and pop.
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1);
        chk("flush_cnt", ENTRY_W'(cnt_o), '0);

        // Lone line2 valid is ignored; following single lands normally.
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Reset mid-operation, then behave as empty.
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0);
        end
        cyc(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
